// File: rtl/alu_pkg.sv
// alu_pkg: definitions shared by the ALU command queue and its circular buffer.
// Holds the opcode encoding and the packed queue entry type. Operand fields
// are sized to ALU_MAX_W so one entry type serves every Width up to that
// limit; the top level zero-extends operands on write and slices them on read.
package alu_pkg;

  typedef enum logic [1:0] {
    OPC_ADD = 2'd0,
    OPC_SUB = 2'd1,
    OPC_AND = 2'd2,
    OPC_OR  = 2'd3
  } alu_opc_e;

  localparam int ALU_MAX_W = 32;

  typedef struct packed {
    alu_opc_e               opc;
    logic [ALU_MAX_W-1:0]   dinA;
    logic [ALU_MAX_W-1:0]   dinB;
  } alu_cmd_t;

endpackage

// File: rtl/alu_cmd_fifo.sv
// alu_cmd_fifo: Depth-entry circular buffer of ALU commands.
// Ports:
//   clk_i    clock, rising edge
//   rst_ni   asynchronous active-low reset (pointers and count only)
//   push_i   write wdata_i at the tail (ignored when full)
//   pop_i    drop the head entry (ignored when empty)
//   wdata_i  entry to write
//   rdata_o  current head entry (meaningful only when not empty)
//   full_o   count equals Depth
//   empty_o  count equals zero
module alu_cmd_fifo
  import alu_pkg::*;
#(
  parameter int Depth = 4
) (
  input  logic     clk_i,
  input  logic     rst_ni,
  input  logic     push_i,
  input  logic     pop_i,
  input  alu_cmd_t wdata_i,
  output alu_cmd_t rdata_o,
  output logic     full_o,
  output logic     empty_o
);

  localparam int PtrW = $clog2(Depth);
  localparam int CntW = PtrW + 1;

  alu_cmd_t          mem [Depth];
  logic [PtrW-1:0]   wrPtr_q, wrPtr_d;
  logic [PtrW-1:0]   rdPtr_q, rdPtr_d;
  logic [CntW-1:0]   count_q, count_d;
  logic              doPush, doPop;

  assign full_o  = (count_q == CntW'(Depth));
  assign empty_o = (count_q == '0);
  assign doPush  = push_i & ~full_o;
  assign doPop   = pop_i & ~empty_o;
  assign rdata_o = mem[rdPtr_q];

  // Depth is a power of two, so pointers wrap modulo Depth simply by
  // overflowing their PtrW bits. Count only moves when exactly one of
  // push/pop happens.
  always_comb begin
    wrPtr_d = wrPtr_q;
    rdPtr_d = rdPtr_q;
    count_d = count_q;
    if (doPush) wrPtr_d = wrPtr_q + PtrW'(1);
    if (doPop)  rdPtr_d = rdPtr_q + PtrW'(1);
    case ({doPush, doPop})
      2'b10:   count_d = count_q + CntW'(1);
      2'b01:   count_d = count_q - CntW'(1);
      default: count_d = count_q;
    endcase
  end

  // Pointer and occupancy registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wrPtr_q <= '0;
      rdPtr_q <= '0;
      count_q <= '0;
    end else begin
      wrPtr_q <= wrPtr_d;
      rdPtr_q <= rdPtr_d;
      count_q <= count_d;
    end
  end

  // Storage is deliberately not reset; a reset empties the queue through
  // the count, which makes stale contents unreachable.
  always_ff @(posedge clk_i) begin
    if (doPush) mem[wrPtr_q] <= wdata_i;
  end

endmodule

// File: rtl/alu_cmd_queue.sv
// alu_cmd_queue: command queue in front of a registered ALU.
// Commands are buffered in alu_cmd_fifo and issued in order whenever the
// consumer is ready; results return one cycle after issue and are tagged with
// a 4-bit issue sequence number.
// Ports:
//   Clk_i, Reset_n_i          clock and asynchronous active-low reset
//   Valid_i/Accept_o          command handshake (Accept_o = not full)
//   Opc_i, DinA_i, DinB_i     command fields
//   Ready_i                   consumer can take a result next cycle
//   AluOpc_o, AluDinA_o/B_o   head entry driven to the ALU (zero when empty)
//   AluDout_i, AluOverFlow_i  registered ALU result and overflow flag
//   ResValid_o, ResDout_o, ResOverFlow_o, ResTag_o   result channel
module alu_cmd_queue
  import alu_pkg::*;
#(
  parameter int Width = 8,
  parameter int Depth = 4
) (
  input  logic             Clk_i,
  input  logic             Reset_n_i,
  input  logic             Valid_i,
  output logic             Accept_o,
  input  logic [1:0]       Opc_i,
  input  logic [Width-1:0] DinA_i,
  input  logic [Width-1:0] DinB_i,
  input  logic             Ready_i,
  output logic [1:0]       AluOpc_o,
  output logic [Width-1:0] AluDinA_o,
  output logic [Width-1:0] AluDinB_o,
  input  logic [Width-1:0] AluDout_i,
  input  logic             AluOverFlow_i,
  output logic             ResValid_o,
  output logic [Width-1:0] ResDout_o,
  output logic             ResOverFlow_o,
  output logic [3:0]       ResTag_o
);

  alu_cmd_t   pushCmd;
  alu_cmd_t   headCmd;
  logic       fifoFull;
  logic       fifoEmpty;
  logic       push;
  logic       issue;
  logic       resValid_q, resValid_d;
  logic [3:0] tagCnt_q, tagCnt_d;
  logic [3:0] resTag_q, resTag_d;

  assign Accept_o = ~fifoFull;
  assign push     = Valid_i & Accept_o;
  assign issue    = ~fifoEmpty & Ready_i;

  // Operands are zero-extended into the shared entry type.
  always_comb begin
    pushCmd      = '0;
    pushCmd.opc  = alu_opc_e'(Opc_i);
    pushCmd.dinA = ALU_MAX_W'(DinA_i);
    pushCmd.dinB = ALU_MAX_W'(DinB_i);
  end

  alu_cmd_fifo #(
    .Depth (Depth)
  ) u_fifo (
    .clk_i   (Clk_i),
    .rst_ni  (Reset_n_i),
    .push_i  (push),
    .pop_i   (issue),
    .wdata_i (pushCmd),
    .rdata_o (headCmd),
    .full_o  (fifoFull),
    .empty_o (fifoEmpty)
  );

  // Blank the ALU inputs when nothing is queued so stale storage never leaks.
  always_comb begin
    AluOpc_o  = '0;
    AluDinA_o = '0;
    AluDinB_o = '0;
    if (!fifoEmpty) begin
      AluOpc_o  = headCmd.opc;
      AluDinA_o = headCmd.dinA[Width-1:0];
      AluDinB_o = headCmd.dinB[Width-1:0];
    end
  end

  // The upper operand bits are always zero; fold them into a sink so they
  // are visibly consumed.
  if (Width < ALU_MAX_W) begin : gPadSink
    logic unusedPad;
    assign unusedPad = ^{headCmd.dinA[ALU_MAX_W-1:Width],
                         headCmd.dinB[ALU_MAX_W-1:Width]};
  end

  // The result strobe follows an issue by one cycle, lining up with the
  // ALU's own output register; the tag is the counter value at that issue.
  always_comb begin
    resValid_d = issue;
    tagCnt_d   = issue ? tagCnt_q + 4'd1 : tagCnt_q;
    resTag_d   = issue ? tagCnt_q : resTag_q;
  end

  // Issue/result state; reset drops any in-flight result.
  always_ff @(posedge Clk_i or negedge Reset_n_i) begin
    if (!Reset_n_i) begin
      resValid_q <= 1'b0;
      tagCnt_q   <= '0;
      resTag_q   <= '0;
    end else begin
      resValid_q <= resValid_d;
      tagCnt_q   <= tagCnt_d;
      resTag_q   <= resTag_d;
    end
  end

  assign ResValid_o    = resValid_q;
  assign ResDout_o     = resValid_q ? AluDout_i : '0;
  assign ResOverFlow_o = resValid_q & AluOverFlow_i;
  assign ResTag_o      = resTag_q;

endmodule

// File: tb/tb_alu_cmd_queue.sv
// tb_alu_cmd_queue: scoreboard bench for alu_cmd_queue with a registered
// ALU model (overflow = carry out for ADD, borrow for SUB, 0 otherwise).
module tb_alu_cmd_queue;
  import alu_pkg::*;

  localparam int DEPTH = 4;

  logic       Clk_i = 1'b0;
  logic       Reset_n_i = 1'b1;
  logic       Valid_i = 1'b0;
  logic       Accept_o;
  logic [1:0] Opc_i = '0;
  logic [7:0] DinA_i = '0;
  logic [7:0] DinB_i = '0;
  logic       Ready_i = 1'b0;
  logic [1:0] AluOpc_o;
  logic [7:0] AluDinA_o;
  logic [7:0] AluDinB_o;
  logic [7:0] AluDout_i = '0;
  logic       AluOverFlow_i = 1'b0;
  logic       ResValid_o;
  logic [7:0] ResDout_o;
  logic       ResOverFlow_o;
  logic [3:0] ResTag_o;

  typedef struct {
    logic [7:0] d;
    logic       o;
    logic [3:0] tag;
  } sbEntryT;

  sbEntryT sb[$];
  sbEntryT monEntry;
  int      checks = 0;
  int      errors = 0;
  int      modelCount = 0;
  logic [3:0] expTag = '0;
  logic    expResValid = 1'b0;
  logic    monEnable = 1'b0;

  alu_cmd_queue #(.Width(8), .Depth(DEPTH)) dut (
    .Clk_i         (Clk_i),
    .Reset_n_i     (Reset_n_i),
    .Valid_i       (Valid_i),
    .Accept_o      (Accept_o),
    .Opc_i         (Opc_i),
    .DinA_i        (DinA_i),
    .DinB_i        (DinB_i),
    .Ready_i       (Ready_i),
    .AluOpc_o      (AluOpc_o),
    .AluDinA_o     (AluDinA_o),
    .AluDinB_o     (AluDinB_o),
    .AluDout_i     (AluDout_i),
    .AluOverFlow_i (AluOverFlow_i),
    .ResValid_o    (ResValid_o),
    .ResDout_o     (ResDout_o),
    .ResOverFlow_o (ResOverFlow_o),
    .ResTag_o      (ResTag_o)
  );

  initial forever #5 Clk_i = ~Clk_i;

  // Registered ALU model fed by the queue's ALU outputs.
  always @(posedge Clk_i) begin
    case (AluOpc_o)
      2'd0:    {AluOverFlow_i, AluDout_i} <= {1'b0, AluDinA_o} + {1'b0, AluDinB_o};
      2'd1:    {AluOverFlow_i, AluDout_i} <= {1'b0, AluDinA_o} - {1'b0, AluDinB_o};
      2'd2:    {AluOverFlow_i, AluDout_i} <= {1'b0, AluDinA_o & AluDinB_o};
      default: {AluOverFlow_i, AluDout_i} <= {1'b0, AluDinA_o | AluDinB_o};
    endcase
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=0x%0h expected=0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: pops the scoreboard whenever a result is presented.
  always @(negedge Clk_i) begin
    if (monEnable) begin
      if (ResValid_o === 1'b1) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL unexpectedResult actual=data 0x%0h tag %0d expected=no result at %0t",
                   ResDout_o, ResTag_o, $time);
        end else begin
          monEntry = sb.pop_front();
          checkOutput("resDout", 32'(ResDout_o), 32'(monEntry.d));
          checkOutput("resOverFlow", 32'(ResOverFlow_o), 32'(monEntry.o));
          checkOutput("resTag", 32'(ResTag_o), 32'(monEntry.tag));
        end
      end else begin
        checkOutput("resIdleZero", 32'({ResOverFlow_o, ResDout_o}), 32'd0);
      end
    end
  end

  // One clock cycle of stimulus: check handshake/strobe timing, drive the
  // inputs, record the expected result of an accepted command.
  task automatic applyStimulus(input logic v, input logic [1:0] op, input logic [7:0] a,
                               input logic [7:0] b, input logic r, input logic [7:0] expD,
                               input logic expO);
    logic doPush, doIssue;
    sbEntryT e;
    @(negedge Clk_i);
    checkOutput("accept", 32'(Accept_o), 32'(modelCount < DEPTH));
    checkOutput("resValidTiming", 32'(ResValid_o), 32'(expResValid));
    Valid_i = v;
    Opc_i   = op;
    DinA_i  = a;
    DinB_i  = b;
    Ready_i = r;
    doPush  = v && (modelCount < DEPTH);
    doIssue = (modelCount > 0) && r;
    if (doPush) begin
      e.d = expD;
      e.o = expO;
      e.tag = expTag;
      sb.push_back(e);
      expTag = expTag + 4'd1;
    end
    modelCount = modelCount + (doPush ? 1 : 0) - (doIssue ? 1 : 0);
    expResValid = doIssue;
    @(posedge Clk_i);
  endtask

  task automatic checkHead(input string name, input logic [1:0] op, input logic [7:0] a,
                           input logic [7:0] b);
    #1;
    checkOutput(name, 32'({AluOpc_o, AluDinA_o, AluDinB_o}), 32'({op, a, b}));
  endtask

  task automatic resetDut();
    @(negedge Clk_i);
    Reset_n_i = 1'b0;
    Valid_i = 1'b1;
    Opc_i = 2'd3;
    DinA_i = 8'hFF;
    DinB_i = 8'hFF;
    Ready_i = 1'b1;
    sb.delete();
    modelCount = 0;
    expTag = '0;
    expResValid = 1'b0;
    repeat (2) @(posedge Clk_i);
    @(negedge Clk_i);
    checkOutput("rstAccept", 32'(Accept_o), 32'd1);
    checkOutput("rstResValid", 32'(ResValid_o), 32'd0);
    checkOutput("rstResTag", 32'(ResTag_o), 32'd0);
    checkOutput("rstAluOut", 32'({AluOpc_o, AluDinA_o, AluDinB_o}), 32'd0);
    Reset_n_i = 1'b1;
    Valid_i = 1'b0;
    Ready_i = 1'b0;
    monEnable = 1'b1;
  endtask

  initial begin
    resetDut();

    // Single ADD with carry: no bypass, result one cycle after issue.
    applyStimulus(1, OPC_ADD, 8'd200, 8'd100, 1, 8'd44, 1'b1);
    checkHead("headAfterPush", OPC_ADD, 8'd200, 8'd100);
    applyStimulus(0, OPC_ADD, 8'd0, 8'd0, 1, 8'd0, 1'b0);
    checkHead("headEmpty", 2'd0, 8'd0, 8'd0);
    applyStimulus(0, OPC_ADD, 8'd0, 8'd0, 1, 8'd0, 1'b0);
    applyStimulus(0, OPC_ADD, 8'd0, 8'd0, 1, 8'd0, 1'b0);

    // Fill to Depth while stalled, offer a fifth, then drain back-to-back.
    resetDut();
    applyStimulus(1, OPC_SUB, 8'd5,    8'd3,    0, 8'd2,    1'b0);
    applyStimulus(1, OPC_AND, 8'hF0,   8'h3C,   0, 8'h30,   1'b0);
    applyStimulus(1, OPC_OR,  8'h0F,   8'h30,   0, 8'h3F,   1'b0);
    applyStimulus(1, OPC_ADD, 8'd1,    8'd1,    0, 8'd2,    1'b0);
    applyStimulus(1, OPC_ADD, 8'd9,    8'd9,    0, 8'd18,   1'b0);
    applyStimulus(0, OPC_ADD, 8'd0,    8'd0,    0, 8'd0,    1'b0);
    checkHead("headFull", OPC_SUB, 8'd5, 8'd3);
    for (int i = 0; i < 6; i++) applyStimulus(0, OPC_ADD, 8'd0, 8'd0, 1, 8'd0, 1'b0);
    checkHead("headDrained", 2'd0, 8'd0, 8'd0);

    // Full queue with simultaneous offer and issue: issue only.
    resetDut();
    applyStimulus(1, OPC_ADD, 8'd255,  8'd1,    0, 8'd0,    1'b1);
    applyStimulus(1, OPC_SUB, 8'd3,    8'd5,    0, 8'hFE,   1'b1);
    applyStimulus(1, OPC_AND, 8'hAA,   8'h0F,   0, 8'h0A,   1'b0);
    applyStimulus(1, OPC_OR,  8'h80,   8'h01,   0, 8'h81,   1'b0);
    applyStimulus(1, OPC_ADD, 8'd7,    8'd8,    1, 8'd15,   1'b0);
    applyStimulus(1, OPC_ADD, 8'd7,    8'd8,    1, 8'd15,   1'b0);
    for (int i = 0; i < 6; i++) applyStimulus(0, OPC_ADD, 8'd0, 8'd0, 1, 8'd0, 1'b0);

    // Seventeen streamed commands: tag wraps 15 -> 0 on the last result.
    resetDut();
    for (int i = 0; i < 17; i++)
      applyStimulus(1, OPC_ADD, 8'(i), 8'd1, 1, 8'(i + 1), 1'b0);
    for (int i = 0; i < 3; i++) applyStimulus(0, OPC_ADD, 8'd0, 8'd0, 1, 8'd0, 1'b0);
    checkOutput("lastTagWrapped", 32'(ResTag_o), 32'd0);

    // Reset right after an issue with three entries queued.
    resetDut();
    applyStimulus(1, OPC_ADD, 8'd1, 8'd2, 0, 8'd3, 1'b0);
    applyStimulus(1, OPC_ADD, 8'd3, 8'd4, 0, 8'd7, 1'b0);
    applyStimulus(1, OPC_ADD, 8'd5, 8'd6, 0, 8'd11, 1'b0);
    @(negedge Clk_i);
    Valid_i = 1'b0;
    Ready_i = 1'b1;
    @(posedge Clk_i);
    #1;
    Reset_n_i = 1'b0;
    sb.delete();
    modelCount = 0;
    expTag = '0;
    expResValid = 1'b0;
    @(negedge Clk_i);
    checkOutput("midRstNoPulse", 32'(ResValid_o), 32'd0);
    checkOutput("midRstAccept", 32'(Accept_o), 32'd1);
    @(negedge Clk_i);
    Reset_n_i = 1'b1;
    for (int i = 0; i < 3; i++) applyStimulus(0, OPC_ADD, 8'd0, 8'd0, 1, 8'd0, 1'b0);
    checkHead("headAfterMidRst", 2'd0, 8'd0, 8'd0);

    @(negedge Clk_i);
    checkOutput("scoreboardEmpty", 32'(sb.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
